sobol_stream_ctrl: RTL
======================

// Module: sobol_stream_ctrl
// PURPOSE
// - Shares one sobolrng instance among NREQ requesters that each need a unipolar stochastic bitstream.
// - Round-robin grants the RNG, clears it, then runs it for LEN cycles.
// - Emits bit = (iRngSeq < latched binary value) each cycle and signals completion per requester.
// - Sits between the binary-to-stochastic front ends and the shared sobolrng.
// PARAMETERS
// - BITWIDTH  8              width of RNG sequence and requester data
// - NREQ      4              number of requesters (>=2)
// - LEN       2**BITWIDTH    bitstream length in cycles (1..2**BITWIDTH)
// PORTS
// - iClk     in   1               clock, rising edge
// - iRst     in   1               synchronous, active-high reset
// - iReq     in   NREQ            per-requester request; held until oDone or deliberately dropped to abort
// - iData    in   NREQ*BITWIDTH   flattened values; requester r at [r*BITWIDTH +: BITWIDTH]
// - iRngSeq  in   BITWIDTH        sobolrng.sobolseq
// - oRngEn   out  1               drives sobolrng.iEn
// - oRngClr  out  1               drives sobolrng.iClr
// - oGnt     out  NREQ            one-hot grant; held CLEAR..DONE
// - oOwner   out  $clog2(NREQ)    index of granted requester
// - oBit     out  1               stochastic bit, valid when oBitVld
// - oBitVld  out  1               high on every RUN cycle
// - oLast    out  1               high on final RUN cycle
// - oDone    out  NREQ            one-cycle pulse to owner in DONE
// BEHAVIOUR
// - Sync reset: state=IDLE, rr pointer=0, cycle counter=0, latched data=0.
// - Sync reset: all outputs 0, including oOwner.
// - Reset mid-operation aborts the run immediately; no oDone pulse.
// - Sobolrng contract: iClr sampled high -> sobolseq=0 and index=0 next cycle.
// - Sobolrng contract: iEn sampled high -> advances one term.
// - IDLE: if |iReq, pick first requester at or after rr pointer (wrapping); register oGnt/oOwner.
// - IDLE: latch iData[owner], counter=0, go CLEAR; otherwise stay.
// - CLEAR (1 cycle): oRngClr=1, oRngEn=0, oGnt held; go RUN.
// - RUN: oRngEn=1, oBitVld=1, oBit=(iRngSeq < latched data), unsigned compare, combinational from registers.
// - RUN: counter increments each cycle; oLast=1 when counter==LEN-1; then go DONE.
// - DONE (1 cycle): oDone[owner]=1, oRngEn=0, rr pointer=(owner+1) mod NREQ; go IDLE.
// - DONE: oGnt/oOwner clear on exit.
// - Latency: request seen in IDLE at cycle t -> CLEAR t+1 -> RUN t+2..t+LEN+1 -> DONE t+LEN+2 -> IDLE t+LEN+3.
// - Min gap between streams: 1 IDLE cycle.
// - Abort: iReq[owner] sampled low in CLEAR or RUN -> next state IDLE, no oDone, pointer still advances.
// - Abort: oBitVld/oRngEn drop the cycle after.
// - Other iReq bits change freely; iData is ignored after latching.
// - Data=0 -> all bits 0. Data=2**BITWIDTH-1 -> exactly LEN-1 ones when LEN=2**BITWIDTH.
// - Counter width $clog2(LEN+1); no wrap inside a run.
// - Simultaneous requests resolve strictly by rr pointer; a requester re-asserting right after its DONE yields to others.
// STRUCTURE
// - Package sobol_ctrl_pkg:
//   - state enum {IDLE, CLEAR, RUN, DONE}
//   - localparam helpers for owner and counter widths
// - Sub-module rr_arbiter #(NREQ): iReq, iPtr -> oGnt one-hot, oIdx; purely combinational.
// - Controller holds FSM, pointer, counter, data latch and compare.
// TESTING (BITWIDTH=8, NREQ=4, LEN=256, real sobolrng attached)
// - Reset with iReq=4'b1111 held -> all outputs 0, state stays IDLE while iRst=1.
// - iReq=4'b0001, data0=128 -> oRngClr at t+1; oBitVld for 256 cycles with exactly 128 ones; oDone=0001 at t+258.
// - iData0=0 and iData0=255 runs -> 0 ones and 255 ones respectively; oLast on 256th valid cycle only.
// - iReq=4'b1010 held from reset -> grant order 1,3,1,3; each oDone pulse is one cycle; one IDLE cycle between runs.
// - Drop iReq[owner] at RUN cycle 40 -> oBitVld falls next cycle, no oDone, next grant goes to owner+1.
// - Assert iRst at RUN cycle 100 -> all outputs 0 next cycle; a new request restarts with oRngClr and sequence from 0.

Source files
------------

// File: rtl/sobol_ctrl_pkg.sv
// Shared types and width helpers for the Sobol bitstream controller.
package sobol_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} ctrlState;

   // Keep index ports at least one bit wide even for degenerate sizes.
   function automatic int unsigned ownerWidth(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cntWidth(input int unsigned len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after iPtr, wrapping.
module rr_arbiter
   import sobol_ctrl_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   localparam int unsigned OW = ownerWidth(NREQ)
) (
   input  logic [NREQ-1:0] iReq,
   input  logic [OW-1:0]   iPtr,
   output logic [NREQ-1:0] oGnt,
   output logic [OW-1:0]   oIdx
);

   logic [OW-1:0] cand;
   logic          found;

   always_comb begin
      oGnt  = '0;
      oIdx  = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = OW'((int'(iPtr) + i) % NREQ);
         if (!found && iReq[cand]) begin
            found      = 1'b1;
            oGnt[cand] = 1'b1;
            oIdx       = cand;
         end
      end
   end

endmodule

// File: rtl/sobol_stream_ctrl.sv
// Time-shares one sobolrng among NREQ requesters: grant, clear the RNG, stream LEN
// comparison bits, then pulse completion to the owner.
module sobol_stream_ctrl
   import sobol_ctrl_pkg::*;
#(
   parameter int unsigned BITWIDTH = 8,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned LEN      = 2 ** BITWIDTH,
   localparam int unsigned OW      = ownerWidth(NREQ)
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic [NREQ-1:0]          iReq,
   input  logic [NREQ*BITWIDTH-1:0] iData,
   input  logic [BITWIDTH-1:0]      iRngSeq,
   output logic                     oRngEn,
   output logic                     oRngClr,
   output logic [NREQ-1:0]          oGnt,
   output logic [OW-1:0]            oOwner,
   output logic                     oBit,
   output logic                     oBitVld,
   output logic                     oLast,
   output logic [NREQ-1:0]          oDone
);

   localparam int unsigned CW = cntWidth(LEN);

   ctrlState            state, stateNext;
   logic [OW-1:0]       ptr, ptrNext;
   logic [OW-1:0]       owner, ownerNext;
   logic [NREQ-1:0]     gnt, gntNext;
   logic [CW-1:0]       cnt, cntNext;
   logic [BITWIDTH-1:0] data, dataNext;
   logic [NREQ-1:0]     arbGnt;
   logic [OW-1:0]       arbIdx;
   logic [OW-1:0]       ownerInc;
   logic                ownerReq;
   logic                cntAtEnd;

   rr_arbiter #(
      .NREQ(NREQ)
   ) uArb (
      .iReq(iReq),
      .iPtr(ptr),
      .oGnt(arbGnt),
      .oIdx(arbIdx)
   );

   assign ownerInc = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
   assign ownerReq = iReq[owner];
   assign cntAtEnd = (cnt == CW'(LEN - 1));

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         gnt   <= '0;
         cnt   <= '0;
         data  <= '0;
      end else begin
         state <= stateNext;
         ptr   <= ptrNext;
         owner <= ownerNext;
         gnt   <= gntNext;
         cnt   <= cntNext;
         data  <= dataNext;
      end
   end

   always_comb begin
      stateNext = state;
      ptrNext   = ptr;
      ownerNext = owner;
      gntNext   = gnt;
      cntNext   = cnt;
      dataNext  = data;
      unique case (state)
         IDLE: begin
            if (|iReq) begin
               gntNext   = arbGnt;
               ownerNext = arbIdx;
               dataNext  = iData[arbIdx*BITWIDTH +: BITWIDTH];
               cntNext   = '0;
               stateNext = CLEAR;
            end
         end
         CLEAR, RUN: begin
            if (!ownerReq) begin
               // Abort: the pointer still moves on so the dropped requester yields.
               ptrNext   = ownerInc;
               gntNext   = '0;
               ownerNext = '0;
               stateNext = IDLE;
            end else if (state == CLEAR) begin
               stateNext = RUN;
            end else begin
               cntNext = cnt + 1'b1;
               if (cntAtEnd) begin
                  stateNext = DONE;
               end
            end
         end
         DONE: begin
            ptrNext   = ownerInc;
            gntNext   = '0;
            ownerNext = '0;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      oRngClr = (state == CLEAR);
      oRngEn  = (state == RUN);
      oBitVld = (state == RUN);
      oBit    = (state == RUN) && (iRngSeq < data);
      oLast   = (state == RUN) && cntAtEnd;
      oDone   = (state == DONE) ? gnt : '0;
      oGnt    = gnt;
      oOwner  = owner;
   end

endmodule
